// File: rtl/axis_nchan_adder.sv
// N_CH-input AXI-stream join/adder: one FIFO per channel, registered sum output.
// Optional statistics ports enabled by AXIS_NCHAN_ADDER_STATS_EN.

module axis_nchan_adder_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                  wr_q, rd_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

module axis_nchan_adder #(
    parameter int DATA_W     = 8,
    parameter int N_CH       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int OUT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] s_axis_data,
    input  logic [N_CH-1:0]        s_axis_valid,
    output logic [N_CH-1:0]        s_axis_ready,
    output logic [OUT_W-1:0]       m_axis_data,
    output logic                   m_axis_valid,
    input  logic                   m_axis_ready
`ifdef AXIS_NCHAN_ADDER_STATS_EN
    ,
    output logic [31:0]            sum_count,
    output logic [N_CH-1:0]        ch_stall
`endif
);
    if (OUT_W < DATA_W + $clog2(N_CH)) begin : g_bad_out_w
        $error("axis_nchan_adder: OUT_W too narrow for N_CH*DATA_W sum");
    end
    if (N_CH < 2) begin : g_bad_n_ch
        $error("axis_nchan_adder: N_CH must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_nchan_adder: FIFO_DEPTH must be a power of 2 >= 2");
    end

    logic                        en_q;
    logic [N_CH-1:0]             full, empty, push;
    logic [N_CH-1:0][DATA_W-1:0] head;
    logic                        fire;
    logic [OUT_W-1:0]            sum_d, data_d, data_q;
    logic                        valid_d, valid_q;

    // en_q holds ready low until the first edge out of reset.
    assign s_axis_ready = {N_CH{en_q}} & ~full;
    assign push         = s_axis_valid & s_axis_ready;
    assign fire         = (&(~empty)) && (!valid_q || m_axis_ready);
    assign m_axis_data  = data_q;
    assign m_axis_valid = valid_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        axis_nchan_adder_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push[i]),
            .pop_i   (fire),
            .data_i  (s_axis_data[i*DATA_W +: DATA_W]),
            .head_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_CH; i++) sum_d = sum_d + OUT_W'(head[i]);
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (fire) begin
            data_d  = sum_d;
            valid_d = 1'b1;
        end else if (m_axis_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            en_q    <= 1'b1;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef AXIS_NCHAN_ADDER_STATS_EN
    logic [31:0]     cnt_q;
    logic [N_CH-1:0] stall_q;

    assign sum_count = cnt_q;
    assign ch_stall  = stall_q;

    // Counter wraps naturally; stall flags are sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            cnt_q   <= cnt_q + 32'(valid_q && m_axis_ready);
            stall_q <= stall_q | (s_axis_valid & ~s_axis_ready);
        end
    end
`endif
endmodule

// File: tb/tb_axis_nchan_adder.sv
// Bench for axis_nchan_adder: directed scenarios plus random traffic against a queue-based model.
module tb_axis_nchan_adder;
    localparam int DATA_W = 8;
    localparam int N_CH   = 2;
    localparam int DEPTH  = 4;
    localparam int OUT_W  = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_CH*DATA_W-1:0] s_axis_data = '0;
    logic [N_CH-1:0]        s_axis_valid = '0;
    logic [N_CH-1:0]        s_axis_ready;
    logic [OUT_W-1:0]       m_axis_data;
    logic                   m_axis_valid;
    logic                   m_axis_ready = 1'b0;
`ifdef AXIS_NCHAN_ADDER_STATS_EN
    logic [31:0]            sum_count;
    logic [N_CH-1:0]        ch_stall;
`endif

    axis_nchan_adder #(
        .DATA_W(DATA_W), .N_CH(N_CH), .FIFO_DEPTH(DEPTH), .OUT_W(OUT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready)
`ifdef AXIS_NCHAN_ADDER_STATS_EN
        ,
        .sum_count    (sum_count),
        .ch_stall     (ch_stall)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per-channel queues of accepted beats, output register, stats.
    logic [DATA_W-1:0] mq[N_CH][$];
    logic              mv = 1'b0;
    logic [OUT_W-1:0]  md = '0;
    logic              started = 1'b0;
    logic [31:0]       scnt = '0;
    logic [N_CH-1:0]   stall = '0;
    logic [OUT_W-1:0]  got[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare against model, advance model at posedge.
    task automatic cyc(input logic [N_CH-1:0] v, input logic [N_CH-1:0][DATA_W-1:0] d,
                       input logic mr);
        logic [N_CH-1:0] rexp;
        logic            fire;
        logic [OUT_W-1:0] s;
        @(negedge clk);
        s_axis_valid = v;
        s_axis_data  = d;
        m_axis_ready = mr;
        #1;
        for (int i = 0; i < N_CH; i++) rexp[i] = started && (mq[i].size() < DEPTH);
        chk("s_ready", 32'(s_axis_ready), 32'(rexp));
        chk("m_valid", 32'(m_axis_valid), 32'(mv));
        chk("m_data", 32'(m_axis_data), 32'(md));
`ifdef AXIS_NCHAN_ADDER_STATS_EN
        chk("sum_count", sum_count, scnt);
        chk("ch_stall", 32'(ch_stall), 32'(stall));
`endif
        if (m_axis_valid && mr) got.push_back(m_axis_data);
        fire = !mv || mr;
        for (int i = 0; i < N_CH; i++) if (mq[i].size() == 0) fire = 1'b0;
        @(posedge clk);
        if (mv && mr) scnt++;
        stall = stall | (v & ~rexp);
        if (fire) begin
            s = '0;
            for (int i = 0; i < N_CH; i++) s = s + OUT_W'(mq[i].pop_front());
            mv = 1'b1;
            md = s;
        end else if (mr) begin
            mv = 1'b0;
        end
        for (int i = 0; i < N_CH; i++) if (v[i] && rexp[i]) mq[i].push_back(d[i]);
        started = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc('0, '0, 1'b1);
    endtask

    task automatic hit_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        s_axis_valid = '0;
        m_axis_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(m_axis_valid), 32'd0);
        chk("rst_data", 32'(m_axis_data), 32'd0);
        chk("rst_ready", 32'(s_axis_ready), 32'd0);
`ifdef AXIS_NCHAN_ADDER_STATS_EN
        chk("rst_sum_count", sum_count, 32'd0);
`endif
        for (int i = 0; i < N_CH; i++) mq[i].delete();
        mv = 1'b0; md = '0; started = 1'b0; scnt = '0; stall = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_low", 32'(s_axis_ready), 32'd0);
        @(posedge clk);
        started = 1'b1;
        #1;
        chk("rel_ready_high", 32'(s_axis_ready), 32'(2'b11));
    endtask

    task automatic chk_got(input string tag, input logic [OUT_W-1:0] exp[$]);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(tag, 32'(got[i]), 32'(exp[i]));
        got.delete();
    endtask

    initial begin
        hit_reset();

        // Basic: FF + FF, visible two edges after the push, for one cycle.
        cyc(2'b11, {8'hFF, 8'hFF}, 1'b1);
        idle(4);
        chk_got("basic", '{16'h01FE});

        // Skew: ch1 arrives long after ch0.
        cyc(2'b01, {8'd0, 8'd3}, 1'b1);
        cyc(2'b01, {8'd0, 8'd5}, 1'b1);
        cyc(2'b01, {8'd0, 8'd7}, 1'b1);
        idle(3);
        cyc(2'b10, {8'd10, 8'd0}, 1'b1);
        cyc(2'b10, {8'd20, 8'd0}, 1'b1);
        cyc(2'b10, {8'd30, 8'd0}, 1'b1);
        idle(4);
        chk_got("skew", '{16'd13, 16'd25, 16'd37});

        // Full FIFO on ch0: only 4 of 6 beats accepted.
        for (int k = 0; k < 6; k++) cyc(2'b01, {8'd0, 8'(10 + k)}, 1'b1);
        #1;
        chk("full_rdy0", 32'(s_axis_ready[0]), 32'd0);
        chk("full_no_out", 32'(got.size()), 32'd0);
        for (int k = 0; k < 4; k++) cyc(2'b10, {8'(k + 1), 8'd0}, 1'b1);
        idle(4);
        chk("full_rdy0_back", 32'(s_axis_ready[0]), 32'd1);
        chk_got("full", '{16'd11, 16'd13, 16'd15, 16'd17});

        // Backpressure: 0x42 pending while 4 more pairs queue up.
        cyc(2'b11, {8'h22, 8'h20}, 1'b0);
        for (int k = 0; k < 10; k++)
            cyc((k < 4) ? 2'b11 : 2'b00, {8'(k + 1), 8'(k + 1)}, 1'b0);
        #1;
        chk("bp_hold_data", 32'(m_axis_data), 32'h42);
        chk("bp_hold_valid", 32'(m_axis_valid), 32'd1);
        idle(8);
        chk_got("bp", '{16'h0042, 16'd2, 16'd4, 16'd6, 16'd8});

        // Mid-operation reset with a pending sum and a buffered pair.
        for (int k = 0; k < 3; k++) cyc(2'b11, {8'd1, 8'd1}, 1'b1);
        idle(3);
        chk_got("pre_rst", '{16'd2, 16'd2, 16'd2});
        cyc(2'b11, {8'd9, 8'd9}, 1'b0);
        cyc(2'b11, {8'd9, 8'd9}, 1'b0);
        cyc('0, '0, 1'b0);
        hit_reset();
        cyc(2'b11, {8'd2, 8'd1}, 1'b1);
        idle(3);
        chk_got("post_rst", '{16'h0003});

        // Random traffic, checked every cycle against the model.
        for (int k = 0; k < 400; k++) begin
            logic [N_CH-1:0]             v;
            logic [N_CH-1:0][DATA_W-1:0] d;
            for (int i = 0; i < N_CH; i++) begin
                v[i] = ($urandom_range(0, 9) < 7);
                d[i] = DATA_W'($urandom);
            end
            cyc(v, d, ($urandom_range(0, 9) < 7));
        end
        idle(8);
        got.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
